clk_div_prog: RTL and testbench

Programmable integer clock divider and the parametrised successor of the fixed divide-by-2 block. It produces a divided clock-enable-style square wave OUT_clk with a run-time-loadable ratio N (2..2^DIV_W-1), plus a rising-edge tick. Ratio changes are glitch-free: they are deferred to a period boundary. It sits between the system clock and slow peripherals, for example encoder sampling and LED or UART pacing.

---
 rtl/clk_div_prog_if.sv | 24 ++
 rtl/clk_div_prog.sv | 80 ++++++++
 tb/tb_clk_div_prog.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/clk_div_prog_if.sv
// Bundle of the divider's control and status signals; the divider uses the
// slave modport and whatever programs it uses the master modport.
interface clk_div_prog_if #(
    parameter int unsigned DIV_W = 16
);
    logic             CE;
    logic             load;
    logic [DIV_W-1:0] ratio_in;
    logic             OUT_clk;
    logic             tick;
    logic             load_ack;
    logic             load_err;
    logic [DIV_W-1:0] ratio_out;

    modport master (
        output CE, load, ratio_in,
        input  OUT_clk, tick, load_ack, load_err, ratio_out
    );

    modport slave (
        input  CE, load, ratio_in,
        output OUT_clk, tick, load_ack, load_err, ratio_out
    );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider. Ratio changes are held pending and
// applied only at a period boundary, so the output never glitches.
module clk_div_prog #(
    parameter int unsigned DIV_W         = 16,
    parameter int unsigned DEFAULT_RATIO = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    clk_div_prog_if.slave bus
);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cur_ratio;
    logic [DIV_W-1:0] pend;
    logic             pend_valid;
    logic             out_q;
    logic             tick_q;
    logic             ack_q;
    logic             err_q;

    logic [DIV_W-1:0] high_time;
    logic             last;
    logic             boundary;
    logic             apply;
    logic             load_ok;
    logic             load_bad;

    always_comb begin
        high_time = cur_ratio >> 1;
        last      = (cnt == cur_ratio - DIV_W'(1));
        // Any idle edge is a boundary, so a ratio can land while stopped.
        boundary  = !bus.CE || last;
        apply     = pend_valid && boundary;
        load_bad  = bus.load && (bus.ratio_in < DIV_W'(2));
        load_ok   = bus.load && !load_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            cur_ratio  <= DIV_W'(DEFAULT_RATIO);
            pend       <= '0;
            pend_valid <= 1'b0;
            out_q      <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (bus.CE) begin
                out_q  <= (cnt < high_time);
                tick_q <= (cnt == '0);
                cnt    <= last ? '0 : cnt + DIV_W'(1);
            end else begin
                out_q  <= 1'b0;
                tick_q <= 1'b0;
                cnt    <= '0;
            end

            ack_q <= apply;
            err_q <= load_bad;

            if (apply) begin
                cur_ratio <= pend;
            end

            // A capture on the applying edge refills pend and keeps it valid.
            if (load_ok) begin
                pend       <= bus.ratio_in;
                pend_valid <= 1'b1;
            end else if (apply) begin
                pend_valid <= 1'b0;
            end
        end
    end

    assign bus.OUT_clk   = out_q;
    assign bus.tick      = tick_q;
    assign bus.load_ack  = ack_q;
    assign bus.load_err  = err_q;
    assign bus.ratio_out = cur_ratio;
endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: per-cycle vectors feed a scoreboard queue
// that an independent monitor drains after every rising edge.
module tb_clk_div_prog;
    localparam int unsigned DIV_W = 16;

    typedef struct packed {
        logic             o;
        logic             t;
        logic             a;
        logic             e;
        logic [DIV_W-1:0] r;
        int               id;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   vec_id     = 0;

    clk_div_prog_if #(.DIV_W(DIV_W)) bus ();

    clk_div_prog #(.DIV_W(DIV_W), .DEFAULT_RATIO(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs for the next rising edge and queue the outputs expected after it.
    task automatic step(input logic ce, input logic ld, input int rin,
                        input logic eo, input logic et, input logic ea,
                        input logic ee, input int er);
        exp_t x;
        @(negedge clk);
        bus.CE       = ce;
        bus.load     = ld;
        bus.ratio_in = DIV_W'(rin);
        vec_id++;
        x.o = eo; x.t = et; x.a = ea; x.e = ee; x.r = DIV_W'(er); x.id = vec_id;
        sb.push_back(x);
    endtask

    task automatic check_reset(input string name);
        compared++;
        if (bus.OUT_clk !== 1'b0 || bus.tick !== 1'b0 || bus.load_ack !== 1'b0 ||
            bus.load_err !== 1'b0 || bus.ratio_out !== DIV_W'(2)) begin
            mismatched++;
            $display("FAIL %s: got out=%b tick=%b ack=%b err=%b ratio=%0d, want 0 0 0 0 ratio=2",
                     name, bus.OUT_clk, bus.tick, bus.load_ack, bus.load_err, bus.ratio_out);
        end
    endtask

    // Monitor: every edge with a queued expectation is compared.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            compared++;
            if (bus.OUT_clk !== x.o || bus.tick !== x.t || bus.load_ack !== x.a ||
                bus.load_err !== x.e || bus.ratio_out !== x.r) begin
                mismatched++;
                $display("FAIL vec%0d: got out=%b tick=%b ack=%b err=%b ratio=%0d, want out=%b tick=%b ack=%b err=%b ratio=%0d",
                         x.id, bus.OUT_clk, bus.tick, bus.load_ack, bus.load_err, bus.ratio_out,
                         x.o, x.t, x.a, x.e, x.r);
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        bus.CE       = 1'b0;
        bus.load     = 1'b0;
        bus.ratio_in = '0;
        #12;
        check_reset("reset_init");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: default N=2 toggles, starting high with a tick
        repeat (3) begin
            step(1, 0, 0, 1, 1, 0, 0, 2);
            step(1, 0, 0, 0, 0, 0, 0, 2);
        end

        // 2: load 5, applied at the wrap, then 2 high / 3 low
        step(1, 1, 5, 1, 1, 0, 0, 2);
        step(1, 0, 0, 0, 0, 1, 0, 5);
        repeat (2) begin
            step(1, 0, 0, 1, 1, 0, 0, 5);
            step(1, 0, 0, 1, 0, 0, 0, 5);
            step(1, 0, 0, 0, 0, 0, 0, 5);
            step(1, 0, 0, 0, 0, 0, 0, 5);
            step(1, 0, 0, 0, 0, 0, 0, 5);
        end

        // 3: rejected loads of 1 and 0
        step(1, 1, 1, 1, 1, 0, 1, 5);
        step(1, 1, 0, 1, 0, 0, 1, 5);
        step(1, 0, 0, 0, 0, 0, 0, 5);
        step(1, 0, 0, 0, 0, 0, 0, 5);
        step(1, 0, 0, 0, 0, 0, 0, 5);

        // 4: load 7 then 4 before the boundary, only 4 lands with one ack
        step(1, 1, 7, 1, 1, 0, 0, 5);
        step(1, 1, 4, 1, 0, 0, 0, 5);
        step(1, 0, 0, 0, 0, 0, 0, 5);
        step(1, 0, 0, 0, 0, 0, 0, 5);
        step(1, 0, 0, 0, 0, 1, 0, 4);
        step(1, 0, 0, 1, 1, 0, 0, 4);
        step(1, 0, 0, 1, 0, 0, 0, 4);
        step(1, 0, 0, 0, 0, 0, 0, 4);
        step(1, 0, 0, 0, 0, 0, 0, 4);

        // 5: go to N=6, drop CE mid-high, restart with a full 3/3 period
        step(1, 1, 6, 1, 1, 0, 0, 4);
        step(1, 0, 0, 1, 0, 0, 0, 4);
        step(1, 0, 0, 0, 0, 0, 0, 4);
        step(1, 0, 0, 0, 0, 1, 0, 6);
        step(1, 0, 0, 1, 1, 0, 0, 6);
        step(1, 0, 0, 1, 0, 0, 0, 6);
        step(0, 0, 0, 0, 0, 0, 0, 6);
        step(0, 0, 0, 0, 0, 0, 0, 6);
        step(1, 0, 0, 1, 1, 0, 0, 6);
        step(1, 0, 0, 1, 0, 0, 0, 6);
        step(1, 0, 0, 1, 0, 0, 0, 6);
        step(1, 0, 0, 0, 0, 0, 0, 6);
        step(1, 0, 0, 0, 0, 0, 0, 6);
        step(1, 0, 0, 0, 0, 0, 0, 6);
        step(1, 0, 0, 1, 1, 0, 0, 6);

        // load while stopped lands on the next idle edge; N=3 is 1 high / 2 low
        step(0, 1, 3, 0, 0, 0, 0, 6);
        step(0, 0, 0, 0, 0, 1, 0, 3);
        step(1, 0, 0, 1, 1, 0, 0, 3);
        step(1, 0, 0, 0, 0, 0, 0, 3);
        step(1, 0, 0, 0, 0, 0, 0, 3);
        step(1, 0, 0, 1, 1, 0, 0, 3);

        // load on the applying wrap edge: 4 applied now, 5 held for the next wrap
        step(1, 1, 4, 0, 0, 0, 0, 3);
        step(1, 1, 5, 0, 0, 1, 0, 4);
        step(1, 0, 0, 1, 1, 0, 0, 4);
        step(1, 0, 0, 1, 0, 0, 0, 4);
        step(1, 0, 0, 0, 0, 0, 0, 4);
        step(1, 0, 0, 0, 0, 1, 0, 5);
        step(1, 0, 0, 1, 1, 0, 0, 5);

        // 6: reset mid-high with 9 pending
        step(1, 1, 9, 1, 0, 0, 0, 5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("reset_mid");
        bus.CE   = 1'b0;
        bus.load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            step(1, 0, 0, 1, 1, 0, 0, 2);
            step(1, 0, 0, 0, 0, 0, 0, 2);
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion, want finish before 100000");
        $fatal(1);
    end
endmodule
